// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath.
package rc4_pkg;

    localparam int unsigned S_DEPTH = 256;
    localparam int unsigned S_AW    = 8;
    localparam int unsigned BYTE_W  = 8;

    // Accepted plaintext alphabet: lowercase letters and space.
    localparam logic [BYTE_W-1:0] CHAR_LO = 8'h61;
    localparam logic [BYTE_W-1:0] CHAR_HI = 8'h7A;
    localparam logic [BYTE_W-1:0] CHAR_SP = 8'h20;

    // S RAM ownership, shared with the shuffle block's mux select.
    localparam logic OWNER_SHUFFLE = 1'b0;
    localparam logic OWNER_PRGA    = 1'b1;

    // One S RAM access request.
    typedef struct packed {
        logic [S_AW-1:0]   addr;
        logic [BYTE_W-1:0] wdata;
        logic              wen;
    } s_req_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_I,
        ST_WAIT_I,
        ST_LATCH_I,
        ST_ADDR_J,
        ST_WAIT_J,
        ST_LATCH_J,
        ST_WR_I,
        ST_WR_J,
        ST_ADDR_F,
        ST_WAIT_F,
        ST_LATCH_F,
        ST_WR_D,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rc4_decrypt_char_check.sv
// Combinational plaintext validity: lowercase letter or space.
module rc4_decrypt_char_check
    import rc4_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic              valid_c
);

    // Byte is acceptable if it falls in the allowed alphabet.
    always_comb begin
        valid_c = ((data >= CHAR_LO) && (data <= CHAR_HI)) || (data == CHAR_SP);
    end

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 PRGA and decrypt engine: walks the S-box left by the shuffle,
// XORs the keystream with the ciphertext ROM and writes the plaintext RAM.
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN     = 32,
    parameter int unsigned MSG_AW      = 5,
    parameter int unsigned CHECK_ASCII = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              fail,
    output logic [S_AW-1:0]   s_addr,
    output logic [BYTE_W-1:0] s_wdata,
    output logic              s_wen,
    input  logic [BYTE_W-1:0] s_q,
    output logic [MSG_AW-1:0] enc_addr,
    input  logic [BYTE_W-1:0] enc_q,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [BYTE_W-1:0] dec_wdata,
    output logic              dec_wen,
    output logic              mem_owner
);

    state_t state;
    state_t state_next;

    logic [S_AW-1:0]   i;
    logic [S_AW-1:0]   j;
    logic [MSG_AW-1:0] k;
    logic [BYTE_W-1:0] si;
    logic [BYTE_W-1:0] sj;
    logic [BYTE_W-1:0] f;
    logic [BYTE_W-1:0] e;

    s_req_t            s_req;
    s_req_t            s_req_next;
    logic [MSG_AW-1:0] enc_addr_next;
    logic [MSG_AW-1:0] dec_addr_next;
    logic [BYTE_W-1:0] dec_wdata_next;
    logic              dec_wen_next;
    logic              done_next;
    logic              mem_owner_next;

    logic [BYTE_W-1:0] plain_c;
    logic              plain_ok_c;
    logic              abort_c;
    logic              last_c;

    assign plain_c = f ^ e;
    assign abort_c = (CHECK_ASCII != 0) && !plain_ok_c;
    assign last_c  = (k == MSG_AW'(MSG_LEN - 1));

    rc4_decrypt_char_check u_char_check (
        .data    (plain_c),
        .valid_c (plain_ok_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed 12-state walk per byte, DONE handshake on start.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_ADDR_I;
            ST_ADDR_I:  state_next = ST_WAIT_I;
            ST_WAIT_I:  state_next = ST_LATCH_I;
            ST_LATCH_I: state_next = ST_ADDR_J;
            ST_ADDR_J:  state_next = ST_WAIT_J;
            ST_WAIT_J:  state_next = ST_LATCH_J;
            ST_LATCH_J: state_next = ST_WR_I;
            ST_WR_I:    state_next = ST_WR_J;
            ST_WR_J:    state_next = ST_ADDR_F;
            ST_ADDR_F:  state_next = ST_WAIT_F;
            ST_WAIT_F:  state_next = ST_LATCH_F;
            ST_LATCH_F: state_next = ST_WR_D;
            ST_WR_D:    state_next = (abort_c || last_c) ? ST_DONE : ST_ADDR_I;
            // Stay at least until done has been shown for one cycle.
            ST_DONE:    if (!start && done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decode; addresses hold between accesses so the RAM sees a stable bus.
    always_comb begin
        s_req_next     = s_req;
        s_req_next.wen = 1'b0;
        enc_addr_next  = enc_addr;
        dec_addr_next  = dec_addr;
        dec_wdata_next = dec_wdata;
        dec_wen_next   = 1'b0;
        done_next      = 1'b0;
        mem_owner_next = OWNER_PRGA;
        case (state)
            ST_IDLE: begin
                mem_owner_next = start ? OWNER_PRGA : OWNER_SHUFFLE;
            end
            ST_ADDR_I: begin
                s_req_next.addr = i;
            end
            ST_ADDR_J: begin
                s_req_next.addr = j;
            end
            ST_WR_I: begin
                s_req_next.addr  = i;
                s_req_next.wdata = sj;
                s_req_next.wen   = 1'b1;
            end
            ST_WR_J: begin
                s_req_next.addr  = j;
                s_req_next.wdata = si;
                s_req_next.wen   = 1'b1;
            end
            ST_ADDR_F: begin
                // Pre-swap si+sj equals post-swap S[i]+S[j].
                s_req_next.addr = S_AW'(si + sj);
                enc_addr_next   = k;
            end
            ST_WR_D: begin
                dec_addr_next  = k;
                dec_wdata_next = plain_c;
                dec_wen_next   = 1'b1;
            end
            ST_DONE: begin
                done_next      = start || !done;
                mem_owner_next = (start || !done) ? OWNER_PRGA : OWNER_SHUFFLE;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_req     <= '0;
            enc_addr  <= '0;
            dec_addr  <= '0;
            dec_wdata <= '0;
            dec_wen   <= 1'b0;
            done      <= 1'b0;
            mem_owner <= OWNER_SHUFFLE;
        end else begin
            s_req     <= s_req_next;
            enc_addr  <= enc_addr_next;
            dec_addr  <= dec_addr_next;
            dec_wdata <= dec_wdata_next;
            dec_wen   <= dec_wen_next;
            done      <= done_next;
            mem_owner <= mem_owner_next;
        end
    end

    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wen   = s_req.wen;

    // PRGA datapath: indices, latched S values, keystream and ciphertext bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            i    <= '0;
            j    <= '0;
            k    <= '0;
            si   <= '0;
            sj   <= '0;
            f    <= '0;
            e    <= '0;
            fail <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i    <= S_AW'(1);
                        j    <= '0;
                        k    <= '0;
                        fail <= 1'b0;
                    end
                end
                ST_LATCH_I: begin
                    si <= s_q;
                    j  <= S_AW'(j + s_q);
                end
                ST_LATCH_J: begin
                    sj <= s_q;
                end
                ST_LATCH_F: begin
                    f <= s_q;
                    e <= enc_q;
                end
                ST_WR_D: begin
                    if (abort_c) begin
                        fail <= 1'b1;
                    end else if (!last_c) begin
                        k <= MSG_AW'(k + MSG_AW'(1));
                        i <= S_AW'(i + S_AW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Directed bench for rc4_decrypt: two instances (ASCII check on / off)
// with synchronous-read memory models and an RC4 reference model.
module tb_rc4_decrypt;

    localparam int unsigned MSG_LEN = 32;
    localparam int unsigned MSG_AW  = 5;

    logic clk;
    logic reset;
    logic start0, start1;
    logic load;

    logic              done0, fail0, s_wen0, dec_wen0, mem_owner0;
    logic [7:0]        s_addr0, s_wdata0, s_q0, enc_q0, dec_wdata0;
    logic [MSG_AW-1:0] enc_addr0, dec_addr0;
    logic              done1, fail1, s_wen1, dec_wen1, mem_owner1;
    logic [7:0]        s_addr1, s_wdata1, s_q1, enc_q1, dec_wdata1;
    logic [MSG_AW-1:0] enc_addr1, dec_addr1;

    logic [7:0] s_init   [256];
    logic [7:0] s_mem0   [256];
    logic [7:0] s_mem1   [256];
    logic [7:0] enc_mem  [MSG_LEN];
    logic [7:0] dec_mem0 [MSG_LEN];
    logic [7:0] dec_mem1 [MSG_LEN];
    logic [23:0] snap;
    int s_wen_cnt0, dec_wen_cnt0, dec_wen_cnt1;

    logic [7:0] ms [256];
    logic [7:0] ks [MSG_LEN];
    logic [7:0] pt [MSG_LEN];

    int vectors    = 0;
    int miscompares = 0;

    rc4_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_ASCII(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .done(done0), .fail(fail0),
        .s_addr(s_addr0), .s_wdata(s_wdata0), .s_wen(s_wen0), .s_q(s_q0),
        .enc_addr(enc_addr0), .enc_q(enc_q0),
        .dec_addr(dec_addr0), .dec_wdata(dec_wdata0), .dec_wen(dec_wen0),
        .mem_owner(mem_owner0)
    );

    rc4_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_ASCII(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .done(done1), .fail(fail1),
        .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wen(s_wen1), .s_q(s_q1),
        .enc_addr(enc_addr1), .enc_q(enc_q1),
        .dec_addr(dec_addr1), .dec_wdata(dec_wdata1), .dec_wen(dec_wen1),
        .mem_owner(mem_owner1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories, write counters and a mid-run S snapshot.
    always @(posedge clk) begin
        if (load) begin
            s_mem0 <= s_init;
            s_mem1 <= s_init;
            for (int n = 0; n < MSG_LEN; n++) begin
                dec_mem0[n] <= 8'hEE;
                dec_mem1[n] <= 8'hEE;
            end
            s_wen_cnt0   <= 0;
            dec_wen_cnt0 <= 0;
            dec_wen_cnt1 <= 0;
        end else begin
            if (s_wen0) begin
                s_mem0[s_addr0] <= s_wdata0;
                s_wen_cnt0      <= s_wen_cnt0 + 1;
            end
            if (s_wen1) s_mem1[s_addr1] <= s_wdata1;
            if (dec_wen0) begin
                dec_mem0[dec_addr0] <= dec_wdata0;
                dec_wen_cnt0        <= dec_wen_cnt0 + 1;
            end
            if (dec_wen1) begin
                dec_mem1[dec_addr1] <= dec_wdata1;
                dec_wen_cnt1        <= dec_wen_cnt1 + 1;
            end
            if (dec_wen0 && dec_addr0 == 5'd2) snap <= {s_mem0[2], s_mem0[3], s_mem0[5]};
        end
        s_q0   <= s_mem0[s_addr0];
        s_q1   <= s_mem1[s_addr1];
        enc_q0 <= enc_mem[enc_addr0];
        enc_q1 <= enc_mem[enc_addr1];
    end

    task automatic load_mem();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic set_identity();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endtask

    // Textbook RC4 PRGA over a copy of s_init.
    task automatic model_run();
        logic [7:0] mi, mj, t, fx;
        mi = 8'd0; mj = 8'd0;
        for (int n = 0; n < 256; n++) ms[n] = s_init[n];
        for (int n = 0; n < MSG_LEN; n++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            fx = ms[mi] + ms[mj];
            ks[n] = ms[fx];
        end
    endtask

    // Raise start, count cycles from the accepting edge until done (bounded).
    task automatic run(input bit which, output int cycles);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            if ((which ? done1 : done0) === 1'b1) break;
        end
    endtask

    task automatic stop();
        @(negedge clk); start0 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (done0 !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done0); miscompares++; end
        vectors++; if (fail0 !== 1'b0) begin $display("FAIL reset_fail: got %b expected 0", fail0); miscompares++; end
        vectors++; if ({s_wen0, dec_wen0} !== 2'b00) begin $display("FAIL reset_wen: got %b expected 00", {s_wen0, dec_wen0}); miscompares++; end
        vectors++; if (mem_owner0 !== 1'b0) begin $display("FAIL reset_owner: got %b expected 0", mem_owner0); miscompares++; end
        vectors++; if ({s_addr0, s_wdata0, dec_wdata0} !== 24'h0) begin $display("FAIL reset_bus: got %h expected 0", {s_addr0, s_wdata0, dec_wdata0}); miscompares++; end
        vectors++; if ({enc_addr0, dec_addr0} !== 10'h0) begin $display("FAIL reset_msg_addr: got %h expected 0", {enc_addr0, dec_addr0}); miscompares++; end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_identity();
        int cyc;
        set_identity();
        model_run();
        for (int n = 0; n < MSG_LEN; n++) enc_mem[n] = ks[n] ^ 8'h61;
        enc_mem[0] = 8'h63; enc_mem[1] = 8'h64; enc_mem[2] = 8'h66;
        load_mem();
        run(1'b0, cyc);
        vectors++; if (cyc != 385) begin $display("FAIL ident_latency: got %0d expected 385", cyc); miscompares++; end
        vectors++; if (fail0 !== 1'b0) begin $display("FAIL ident_fail: got %b expected 0", fail0); miscompares++; end
        vectors++; if (snap !== 24'h030502) begin $display("FAIL ident_swap_s2_s3_s5: got %h expected 030502", snap); miscompares++; end
        for (int n = 0; n < MSG_LEN; n++) begin
            vectors++;
            if (dec_mem0[n] !== 8'h61) begin $display("FAIL ident_dec[%0d]: got %h expected 61", n, dec_mem0[n]); miscompares++; end
        end
        vectors++; if (dec_wen_cnt0 != 32) begin $display("FAIL ident_dec_wen_count: got %0d expected 32", dec_wen_cnt0); miscompares++; end
        vectors++; if (s_wen_cnt0 != 64) begin $display("FAIL ident_s_wen_count: got %0d expected 64", s_wen_cnt0); miscompares++; end
    endtask

    // Entered with start0 still high from the previous run.
    task automatic test_hold_restart();
        int c0, c1;
        c0 = s_wen_cnt0; c1 = dec_wen_cnt0;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (done0 !== 1'b1) begin $display("FAIL hold_done: got %b expected 1", done0); miscompares++; end
        vectors++; if (mem_owner0 !== 1'b1) begin $display("FAIL hold_owner: got %b expected 1", mem_owner0); miscompares++; end
        vectors++; if (s_wen_cnt0 != c0 || dec_wen_cnt0 != c1) begin $display("FAIL hold_writes: got %0d/%0d expected %0d/%0d", s_wen_cnt0, dec_wen_cnt0, c0, c1); miscompares++; end
        stop();
        vectors++; if (done0 !== 1'b0) begin $display("FAIL release_done: got %b expected 0", done0); miscompares++; end
        vectors++; if (mem_owner0 !== 1'b0) begin $display("FAIL release_owner: got %b expected 0", mem_owner0); miscompares++; end
        set_identity();
        s_init[1] = 8'h07; s_init[7] = 8'h01;
        load_mem();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        vectors++; if (s_addr0 !== 8'h01) begin $display("FAIL restart_i_addr: got %h expected 01", s_addr0); miscompares++; end
        vectors++; if (mem_owner0 !== 1'b1) begin $display("FAIL restart_owner: got %b expected 1", mem_owner0); miscompares++; end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (s_addr0 !== 8'h07) begin $display("FAIL restart_j_addr: got %h expected 07", s_addr0); miscompares++; end
        for (int n = 0; n < 2000 && done0 !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        vectors++; if (done0 !== 1'b1) begin $display("FAIL restart_done: got %b expected 1", done0); miscompares++; end
        stop();
    endtask

    task automatic test_ascii_abort();
        int cyc;
        set_identity();
        enc_mem[0] = 8'h02;
        load_mem();
        run(1'b0, cyc);
        vectors++; if (cyc != 13) begin $display("FAIL abort_latency: got %0d expected 13", cyc); miscompares++; end
        vectors++; if (fail0 !== 1'b1) begin $display("FAIL abort_fail: got %b expected 1", fail0); miscompares++; end
        vectors++; if (dec_mem0[0] !== 8'h00) begin $display("FAIL abort_dec0: got %h expected 00", dec_mem0[0]); miscompares++; end
        vectors++; if (dec_wen_cnt0 != 1) begin $display("FAIL abort_dec_wen_count: got %0d expected 1", dec_wen_cnt0); miscompares++; end
        vectors++; if (dec_mem0[1] !== 8'hEE) begin $display("FAIL abort_dec1_untouched: got %h expected ee", dec_mem0[1]); miscompares++; end
        stop();
    endtask

    task automatic test_no_check();
        int cyc;
        set_identity();
        load_mem();
        run(1'b1, cyc);
        vectors++; if (cyc != 385) begin $display("FAIL nocheck_latency: got %0d expected 385", cyc); miscompares++; end
        vectors++; if (fail1 !== 1'b0) begin $display("FAIL nocheck_fail: got %b expected 0", fail1); miscompares++; end
        vectors++; if (dec_wen_cnt1 != 32) begin $display("FAIL nocheck_dec_wen_count: got %0d expected 32", dec_wen_cnt1); miscompares++; end
        vectors++; if (dec_mem1[0] !== 8'h00) begin $display("FAIL nocheck_dec0: got %h expected 00", dec_mem1[0]); miscompares++; end
        for (int n = 1; n < MSG_LEN; n++) begin
            vectors++;
            if (dec_mem1[n] !== 8'h61) begin $display("FAIL nocheck_dec[%0d]: got %h expected 61", n, dec_mem1[n]); miscompares++; end
        end
        stop();
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_identity();
        enc_mem[0] = 8'h63;
        load_mem();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        repeat (67) @(posedge clk);
        #1;
        vectors++; if (s_wen0 !== 1'b1 || s_addr0 !== 8'h06) begin $display("FAIL mid_wr_i_byte5: got wen=%b addr=%h expected wen=1 addr=06", s_wen0, s_addr0); miscompares++; end
        reset = 1'b1; start0 = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({s_wen0, dec_wen0} !== 2'b00) begin $display("FAIL mid_reset_wen: got %b expected 00", {s_wen0, dec_wen0}); miscompares++; end
        vectors++; if (done0 !== 1'b0) begin $display("FAIL mid_reset_done: got %b expected 0", done0); miscompares++; end
        vectors++; if (mem_owner0 !== 1'b0) begin $display("FAIL mid_reset_owner: got %b expected 0", mem_owner0); miscompares++; end
        @(negedge clk); reset = 1'b0;
        load_mem();
        run(1'b0, cyc);
        vectors++; if (cyc != 385) begin $display("FAIL rerun_latency: got %0d expected 385", cyc); miscompares++; end
        vectors++; if (fail0 !== 1'b0) begin $display("FAIL rerun_fail: got %b expected 0", fail0); miscompares++; end
        vectors++; if (dec_mem0[0] !== 8'h61 || dec_mem0[31] !== 8'h61) begin $display("FAIL rerun_dec: got %h/%h expected 61/61", dec_mem0[0], dec_mem0[31]); miscompares++; end
        stop();
    endtask

    task automatic test_random();
        int cyc, r;
        logic [7:0] t;
        set_identity();
        for (int n = 255; n > 0; n--) begin
            r = int'($urandom_range(n, 0));
            t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
        end
        for (int n = 0; n < MSG_LEN; n++) begin
            r = int'($urandom_range(26, 0));
            pt[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end
        model_run();
        for (int n = 0; n < MSG_LEN; n++) enc_mem[n] = pt[n] ^ ks[n];
        load_mem();
        run(1'b0, cyc);
        vectors++; if (cyc != 385) begin $display("FAIL rand_latency: got %0d expected 385", cyc); miscompares++; end
        vectors++; if (fail0 !== 1'b0) begin $display("FAIL rand_fail: got %b expected 0", fail0); miscompares++; end
        for (int n = 0; n < MSG_LEN; n++) begin
            vectors++;
            if (dec_mem0[n] !== pt[n]) begin $display("FAIL rand_dec[%0d]: got %h expected %h", n, dec_mem0[n], pt[n]); miscompares++; end
        end
        for (int n = 0; n < 256; n++) begin
            vectors++;
            if (s_mem0[n] !== ms[n]) begin $display("FAIL rand_s[%0d]: got %h expected %h", n, s_mem0[n], ms[n]); miscompares++; end
        end
        vectors++; if (s_wen_cnt0 != 64) begin $display("FAIL rand_s_wen_count: got %0d expected 64", s_wen_cnt0); miscompares++; end
        vectors++; if (dec_wen_cnt0 != 32) begin $display("FAIL rand_dec_wen_count: got %0d expected 32", dec_wen_cnt0); miscompares++; end
        stop();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_hold_restart();
        test_ascii_abort();
        test_no_check();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
